// File: rtl/calc1_port_driver.sv
// Request-side driver for one calc1 port: queues complete operations, serialises
// each onto the two-cycle cmd/data request protocol and returns the response or a timeout.
module calc1_port_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [0:3]  op_cmd,
    input  logic [0:31] op_data1,
    input  logic [0:31] op_data2,
    output logic [0:3]  req_cmd_out,
    output logic [0:31] req_data_out,
    input  logic [0:1]  out_resp,
    input  logic [0:31] out_data,
    output logic        res_valid,
    output logic [0:1]  res_resp,
    output logic [0:31] res_data,
    output logic        res_timeout,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [0:3]  cmd;
        logic [0:31] d1;
        logic [0:31] d2;
    } op_t;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DAT, S_WAIT, S_HALT} state_t;

    state_t        state, state_d;
    op_t           fifo [FIFO_DEPTH];
    op_t           cur;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          empty, full, push, pop, resp_hit, to_hit;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign op_ready = !full && (state != S_HALT);
    // NOPs complete the handshake but never occupy a slot
    assign push     = op_valid && op_ready && (op_cmd != 4'd0);
    assign busy     = (state != S_IDLE) || !empty;

    always_comb begin
        state_d      = state;
        req_cmd_out  = '0;
        req_data_out = '0;
        pop          = 1'b0;
        resp_hit     = 1'b0;
        to_hit       = 1'b0;
        case (state)
            S_IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = S_CMD;
            end
            S_CMD: begin
                req_cmd_out  = cur.cmd;
                req_data_out = cur.d1;
                state_d      = S_DAT;
            end
            S_DAT: begin
                req_data_out = cur.d2;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // a response on the final counted edge still wins over timeout
                if (out_resp != 2'd0) begin
                    resp_hit = 1'b1;
                    state_d  = S_IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    to_hit  = 1'b1;
                    state_d = S_HALT;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (push) fifo[wr_ptr[AW-1:0]] <= '{cmd: op_cmd, d1: op_data1, d2: op_data2};
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            cur         <= '0;
            res_valid   <= 1'b0;
            res_resp    <= '0;
            res_data    <= '0;
            res_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            res_valid   <= resp_hit || to_hit;
            res_timeout <= to_hit;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cur    <= fifo[rd_ptr[AW-1:0]];
            end
            if (state == S_DAT) cnt <= '0;
            else if (state == S_WAIT && cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
            if (resp_hit) begin
                res_resp <= out_resp;
                res_data <= out_data;
            end else if (to_hit) begin
                res_resp <= '0;
                res_data <= '0;
            end
        end
    end
endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed bench for calc1_port_driver: one task per scenario, hand-computed expectations.
module tb_calc1_port_driver;
    logic        c_clk, reset, op_valid, op_ready;
    logic [0:3]  op_cmd, req_cmd_out;
    logic [0:31] op_data1, op_data2, req_data_out, out_data, res_data;
    logic [0:1]  out_resp, res_resp;
    logic        res_valid, res_timeout, busy;
    int          checks = 0;
    int          errors = 0;

    calc1_port_driver #(.FIFO_DEPTH(4), .TIMEOUT(63)) dut (
        .c_clk(c_clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_cmd(op_cmd), .op_data1(op_data1), .op_data2(op_data2),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
        .out_resp(out_resp), .out_data(out_data),
        .res_valid(res_valid), .res_resp(res_resp), .res_data(res_data),
        .res_timeout(res_timeout), .busy(busy)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish before 400us");
        $fatal(1);
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    // offer one op until accepted (bounded); leaves op_valid low after the accept edge
    task automatic offer(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b, output bit ok);
        ok = 1'b0;
        op_valid = 1'b1; op_cmd = c; op_data1 = a; op_data2 = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (op_ready) ok = 1'b1;
            tick();
        end
        op_valid = 1'b0;
    endtask

    task automatic wait_cmd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_cmd_out != 4'd0) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge c_clk);
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got %b exp 1", op_ready); end
        checks++; if ({req_cmd_out, req_data_out} !== 36'h0) begin errors++; $display("FAIL reset_req got %h/%h exp 0/0", req_cmd_out, req_data_out); end
        checks++; if ({res_valid, res_resp, res_data, res_timeout, busy} !== 37'h0) begin errors++;
            $display("FAIL reset_res got v%b r%h d%h t%b b%b exp all 0", res_valid, res_resp, res_data, res_timeout, busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        bit ok;
        offer(4'd1, 32'h5, 32'h3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_accept got no accept exp accept"); end
        checks++; if (req_cmd_out !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL add_idle_gap got cmd %h busy %b exp 0/1", req_cmd_out, busy); end
        tick();
        checks++; if (req_cmd_out !== 4'd1 || req_data_out !== 32'h5) begin errors++; $display("FAIL add_cmd got %h/%h exp 1/5", req_cmd_out, req_data_out); end
        tick();
        checks++; if (req_cmd_out !== 4'd0 || req_data_out !== 32'h3) begin errors++; $display("FAIL add_dat got %h/%h exp 0/3", req_cmd_out, req_data_out); end
        tick();
        checks++; if (req_cmd_out !== 4'd0 || req_data_out !== 32'h0) begin errors++; $display("FAIL add_wait got %h/%h exp 0/0", req_cmd_out, req_data_out); end
        tick(); tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_early_res got %b exp 0", res_valid); end
        out_resp = 2'd1; out_data = 32'h8;
        tick();
        out_resp = 2'd0; out_data = 32'hdead_beef;
        checks++; if ({res_valid, res_resp, res_data, res_timeout} !== {1'b1, 2'd1, 32'h8, 1'b0}) begin errors++;
            $display("FAIL add_res got v%b r%h d%h t%b exp v1 r1 d8 t0", res_valid, res_resp, res_data, res_timeout); end
        tick();
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 32'h8) begin errors++;
            $display("FAIL add_after got v%b b%b d%h exp v0 b0 d8", res_valid, busy, res_data); end
    endtask

    task automatic test_backpressure();
        bit ok, bad;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op_valid = 1'b1; op_cmd = (i % 2 == 0) ? 4'd1 : 4'd2;
            op_data1 = 32'h100 + i; op_data2 = 32'h200 + i;
            if (op_ready !== 1'b1) bad = 1'b1;
            tick();
        end
        checks++; if (bad) begin errors++; $display("FAIL bp_ready_fill got low exp high"); end
        op_cmd = 4'd2; op_data1 = 32'h105; op_data2 = 32'h205;
        checks++; if (op_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_full got rdy %b busy %b exp 0/1", op_ready, busy); end
        out_resp = 2'd1; out_data = 32'hA0;
        tick();
        out_resp = 2'd0;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'hA0 || op_ready !== 1'b0) begin errors++;
            $display("FAIL bp_first_res got v%b d%h rdy %b exp v1 dA0 rdy0", res_valid, res_data, op_ready); end
        tick();
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %b exp 1", op_ready); end
        for (int k = 1; k < 6; k++) begin
            wait_cmd(ok);
            checks++; if (!ok || req_cmd_out !== ((k % 2 == 0) ? 4'd1 : 4'd2) || req_data_out !== 32'h100 + k) begin errors++;
                $display("FAIL bp_order_cmd%0d got %h/%h exp %h/%h", k, req_cmd_out, req_data_out, (k % 2 == 0) ? 1 : 2, 32'h100 + k); end
            tick();
            op_valid = 1'b0;
            checks++; if (req_cmd_out !== 4'd0 || req_data_out !== 32'h200 + k) begin errors++;
                $display("FAIL bp_order_dat%0d got %h/%h exp 0/%h", k, req_cmd_out, req_data_out, 32'h200 + k); end
            tick();
            out_resp = 2'd1; out_data = 32'hA0 + k;
            tick();
            out_resp = 2'd0;
            checks++; if (res_valid !== 1'b1 || res_data !== 32'hA0 + k) begin errors++;
                $display("FAIL bp_res%0d got v%b d%h exp v1 d%h", k, res_valid, res_data, 32'hA0 + k); end
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_drain got busy %b exp 0", busy); end
    endtask

    task automatic test_timeout();
        bit ok, bad;
        offer(4'd1, 32'h1, 32'h2, ok);
        wait_cmd(ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_start got no cmd exp cmd"); end
        tick(); tick();
        bad = 1'b0;
        for (int i = 0; i < 62; i++) begin
            tick();
            if (res_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL to_early got res_valid exp none before edge 63"); end
        tick();
        checks++; if ({res_valid, res_timeout, res_resp, res_data} !== {1'b1, 1'b1, 2'd0, 32'h0}) begin errors++;
            $display("FAIL to_fire got v%b t%b r%h d%h exp v1 t1 r0 d0", res_valid, res_timeout, res_resp, res_data); end
        op_valid = 1'b1; op_cmd = 4'd1; op_data1 = 32'h7; op_data2 = 32'h7;
        out_resp = 2'd1; out_data = 32'h55;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (op_ready !== 1'b0 || req_cmd_out !== 4'd0 || req_data_out !== 32'h0 || res_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        op_valid = 1'b0; out_resp = 2'd0;
        checks++; if (bad) begin errors++; $display("FAIL to_halt got activity exp frozen halt"); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (op_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_reset got rdy %b busy %b exp 1/0", op_ready, busy); end
        offer(4'd1, 32'h10, 32'h20, ok);
        wait_cmd(ok);
        tick(); tick();
        out_resp = 2'd1; out_data = 32'h30;
        tick();
        out_resp = 2'd0;
        checks++; if (!ok || {res_valid, res_resp, res_data, res_timeout} !== {1'b1, 2'd1, 32'h30, 1'b0}) begin errors++;
            $display("FAIL to_recover got v%b r%h d%h t%b exp v1 r1 d30 t0", res_valid, res_resp, res_data, res_timeout); end
        tick();
    endtask

    task automatic test_collision();
        bit ok;
        offer(4'd2, 32'hA, 32'h3, ok);
        wait_cmd(ok);
        tick(); tick();
        repeat (62) tick();
        out_resp = 2'd2; out_data = 32'h0;
        tick();
        out_resp = 2'd0;
        checks++; if (!ok || {res_valid, res_timeout, res_resp, res_data} !== {1'b1, 1'b0, 2'd2, 32'h0}) begin errors++;
            $display("FAIL coll_res got v%b t%b r%h d%h exp v1 t0 r2 d0", res_valid, res_timeout, res_resp, res_data); end
        tick();
        checks++; if (op_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL coll_idle got rdy %b busy %b exp 1/0", op_ready, busy); end
    endtask

    task automatic test_reset_dat();
        bit bad;
        op_valid = 1'b1; op_cmd = 4'd5; op_data1 = 32'h11; op_data2 = 32'h22;
        tick();
        op_cmd = 4'd6; op_data1 = 32'h33; op_data2 = 32'h44;
        tick();
        op_valid = 1'b0;
        tick();
        checks++; if (req_cmd_out !== 4'd0 || req_data_out !== 32'h22) begin errors++; $display("FAIL rst_dat_pre got %h/%h exp 0/22", req_cmd_out, req_data_out); end
        #3 reset = 1'b1;
        #1;
        checks++; if ({req_cmd_out, req_data_out} !== 36'h0 || busy !== 1'b0 || op_ready !== 1'b1 || res_valid !== 1'b0) begin errors++;
            $display("FAIL rst_dat_async got %h/%h busy %b rdy %b v%b exp 0/0 b0 r1 v0", req_cmd_out, req_data_out, busy, op_ready, res_valid); end
        tick();
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0 || req_cmd_out !== 4'd0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL rst_dat_quiet got activity exp quiet and empty"); end
    endtask

    task automatic test_nop();
        bit bad;
        op_valid = 1'b1; op_cmd = 4'd0; op_data1 = 32'h99; op_data2 = 32'h98;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL nop_ready got %b exp 1", op_ready); end
        tick();
        op_valid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b0 || req_cmd_out !== 4'd0 || req_data_out !== 32'h0 || res_valid !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++; if (bad) begin errors++; $display("FAIL nop_quiet got activity exp none"); end
    endtask

    initial begin
        reset = 1'b0; op_valid = 1'b0; op_cmd = '0; op_data1 = '0; op_data2 = '0;
        out_resp = 2'bxx; out_data = 'x;
        #2;
        test_reset();
        out_resp = 2'd0; out_data = '0;
        test_add();
        test_backpressure();
        test_timeout();
        test_collision();
        test_reset_dat();
        test_nop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/calc1_port_driver.md
# calc1_port_driver

Request-side driver for one calc1 calculator port. Accepts complete operations (command plus two operands) from a bench or sequencer through a valid/ready interface and buffers them in a small FIFO. Serialises each operation onto the calculator's two-cycle request protocol, waits for the port's response and returns it with a timeout indication. One instance is used per calculator port (four per calculator).

## Interface

Parameters:

- FIFO_DEPTH, 4 — number of queued operations (power of two, ≥2).
- TIMEOUT, 63 — maximum number of WAIT cycles before an operation is declared lost.

Ports:

- c_clk  in  1  — single clock; all state updates on the rising edge.
- reset  in  1  — asynchronous, active-high reset.
- op_valid  in  1  — operation offered.
- op_ready  out  1  — driver can accept the operation.
- op_cmd  in  [0:3]  — calculator command: 1=ADD, 2=SUB, 5=LSH, 6=RSH, others passed through unchanged.
- op_data1  in  [0:31]  — operand 1.
- op_data2  in  [0:31]  — operand 2.
- req_cmd_out  out  [0:3]  — drives the calculator port's req_cmd_in.
- req_data_out  out  [0:31]  — drives the calculator port's req_data_in.
- out_resp  in  [0:1]  — calculator port response: 0=none, 1=success, 2=invalid/overflow, 3=internal error.
- out_data  in  [0:31]  — calculator port result.
- res_valid  out  1  — one-cycle result strobe.
- res_resp  out  [0:1]  — captured response code.
- res_data  out  [0:31]  — captured result.
- res_timeout  out  1  — qualifies res_valid: the operation timed out.
- busy  out  1  — high when state ≠ IDLE or the FIFO is non-empty.

## Operation

- **Enqueue**
  - An operation is accepted on a rising edge with op_valid && op_ready; {op_cmd, op_data1, op_data2} is written to the FIFO.
  - op_cmd == 0 (NOP) is accepted (op_ready honoured) but discarded: not enqueued, no response.
  - op_ready = FIFO not full && state ≠ HALT.
  - There is no bypass: a write to an empty FIFO is visible to the FSM on the next edge.
- **FSM states**
  - IDLE: req_cmd_out=0, req_data_out=0. On an edge with FIFO non-empty, pop the head and go to CMD.
  - CMD: req_cmd_out=cmd, req_data_out=data1 for exactly one cycle, then go to DAT.
  - DAT: req_cmd_out=0, req_data_out=data2 for exactly one cycle, then go to WAIT with the timeout counter cleared to 0.
  - WAIT: req_cmd_out=0, req_data_out=0. out_resp is sampled each edge.
    - out_resp ∈ {1,2,3}: capture out_resp/out_data into res_resp/res_data, pulse res_valid with res_timeout=0, go to IDLE.
    - Otherwise increment the counter.
    - Counter == TIMEOUT with no response: pulse res_valid with res_timeout=1, res_resp=0, res_data=0, go to HALT.
    - A response on the same edge the counter reaches TIMEOUT is a normal response; the response wins.
  - HALT: req outputs 0, op_ready=0, FIFO contents frozen. Exit only by reset, since a late calculator response cannot be attributed.
- out_resp is ignored outside WAIT, so X or floating values before the calculator's first result are harmless.
- At most one operation is outstanding. IDLE always occupies at least one cycle between operations, so the calculator returns to its idle state.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
- res_resp/res_data hold their value after the strobe until the next capture.

## Timing

- **Reset value of every output:** op_ready=1, req_cmd_out=0, req_data_out=0, res_valid=0, res_resp=0, res_data=0, res_timeout=0, busy=0.
  - Reset also sets state=IDLE, empties the FIFO and clears the counter.
- Reset mid-operation (any state) abandons the operation. req_cmd_out/req_data_out go to 0 asynchronously, with no res_valid.
- Accept on edge E into an idle, empty driver:
  - Edge E+1: CMD entered; cmd/data1 driven during cycle E+1..E+2.
  - Edge E+2: data2 driven.
  - Edge E+3: WAIT entered.
- A response sampled on edge R gives res_valid high for cycle R..R+1. The next CMD is entered no earlier than R+1 (IDLE for one cycle).
- Full FIFO: op_ready low. A pop frees a slot, and op_ready rises on the cycle after the pop edge.
- Request outputs change only on rising edges, so they are stable at the calculator's falling-edge sampling point.

## Test plan

- **ADD:** op ADD, 0x00000005, 0x00000003, with the calculator answering resp=1, data=0x00000008 three cycles into WAIT.
  - Request pattern: cmd 1/data 5, then cmd 0/data 3.
  - Result: one res_valid with res_resp=1, res_data=0x00000008, res_timeout=0; busy low the next cycle.
- **Backpressure:** FIFO_DEPTH=4, calculator silent, six ops pushed back-to-back.
  - Op 1 is popped and four are queued; op_ready drops on the sixth offer.
  - After a response, op_ready rises and the sixth op is accepted; ops complete in order.
- **Timeout:** TIMEOUT=63, no response.
  - The 63rd WAIT edge gives res_valid with res_timeout=1, res_resp=0.
  - op_ready stays 0 and req outputs stay 0 until reset; after reset a new ADD completes normally.
- **Response/timeout collision:** response resp=2, data=0 arrives on the same edge the counter reaches TIMEOUT.
  - Result: res_timeout=0, res_resp=2, state returns to IDLE (not HALT).
- **Reset during DAT:** reset asserted while data2 is driven.
  - Outputs go to reset values immediately, the FIFO empties and no res_valid appears.
- **NOP:** op_cmd=0 offered.
  - Accepted with no request driven, no res_valid and busy staying 0.
